// File: rtl/mlp_dnd_sequencer.sv
// Time-multiplexed two-layer MLP inference controller sharing one MAC across both layers.
// Optional perf counters (perf_events, perf_signal) enabled by `define MLP_DND_SEQ_PERF_CNT_EN.
module mlp_dnd_sequencer #(
  parameter int unsigned N1    = 98,
  parameter int unsigned N2    = 10,
  parameter int unsigned MAG_W = 4,
  parameter int unsigned HID_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N1/2-1:0][MAG_W-1:0]          in_mag,
  input  logic [N1/2-1:0][1:0]                in_pol,
  input  logic [N2-1:0][N1/2:0][5:0]          weights_n1_mag,
  input  logic [N2-1:0][N1/2:0][5:0]          weights_n1_pol,
  input  logic [N2:0][3:0]                    weights_n2,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACC_W-1:0]                    out_score,
`ifdef MLP_DND_SEQ_PERF_CNT_EN
  output logic                                out_class,
  output logic [15:0]                         perf_events,
  output logic [15:0]                         perf_signal
`else
  output logic                                out_class
`endif
);

  localparam int unsigned NH = N1 / 2;
  localparam int unsigned IW = $clog2(NH);
  localparam int unsigned JW = $clog2(N2 + 1);

  typedef enum logic [1:0] {StIdle, StL1, StL2, StDone} state_e;

  state_e                       state_q;
  logic [IW-1:0]                i_q;
  logic [JW-1:0]                j_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic [NH-1:0][MAG_W-1:0]     mag_q;
  logic [NH-1:0][1:0]           pol_q;
  logic [N2-1:0][HID_W-1:0]     hid_q;

  logic [JW-1:0]                jh;
  logic [5:0]                   w_mag, w_pol, w_bias;
  logic [3:0]                   w2, w2_bias;
  logic [HID_W-1:0]             hid_sel, hid_new;
  logic signed [ACC_W-1:0]      wm_x, mg_x, wp_x, pl_x, wb_x, w2_x, hd_x, w2b_x;
  logic signed [ACC_W-1:0]      term1, base1, sum1, term2, base2, sum2;

  always_comb begin
    // L2 runs one extra cycle with j == N2; clamp so hidden-layer reads stay in range
    jh      = (j_q >= JW'(N2)) ? '0 : j_q;
    w_mag   = weights_n1_mag[jh][i_q];
    w_pol   = weights_n1_pol[jh][i_q];
    w_bias  = weights_n1_mag[jh][NH];
    w2      = weights_n2[j_q];
    w2_bias = weights_n2[N2];
    hid_sel = hid_q[jh];

    wm_x  = {{(ACC_W-6){w_mag[5]}}, w_mag};
    mg_x  = {{(ACC_W-MAG_W){1'b0}}, mag_q[i_q]};
    wp_x  = {{(ACC_W-6){w_pol[5]}}, w_pol};
    pl_x  = {{(ACC_W-2){pol_q[i_q][1]}}, pol_q[i_q]};
    wb_x  = {{(ACC_W-6){w_bias[5]}}, w_bias};
    w2_x  = {{(ACC_W-4){w2[3]}}, w2};
    hd_x  = {{(ACC_W-HID_W){1'b0}}, hid_sel};
    w2b_x = {{(ACC_W-4){w2_bias[3]}}, w2_bias};

    term1 = wm_x * mg_x + wp_x * pl_x;
    base1 = (i_q == '0) ? wb_x : acc_q;
    sum1  = base1 + term1;
    term2 = w2_x * hd_x;
    base2 = (j_q == '0) ? w2b_x : acc_q;
    sum2  = base2 + term2;

    // ReLU with saturation: negative -> 0, any bit above HID_W set -> all ones
    if (sum1[ACC_W-1]) begin
      hid_new = '0;
    end else if (|sum1[ACC_W-2:HID_W]) begin
      hid_new = '1;
    end else begin
      hid_new = sum1[HID_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_score <= '0;
      out_class <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      pol_q     <= '0;
      hid_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mag_q    <= in_mag;
            pol_q    <= in_pol;
            i_q      <= '0;
            j_q      <= '0;
            in_ready <= 1'b0;
            state_q  <= StL1;
          end
        end
        StL1: begin
          acc_q <= sum1;
          if (i_q == IW'(NH - 1)) begin
            hid_q[jh] <= hid_new;
            i_q       <= '0;
            if (j_q == JW'(N2 - 1)) begin
              j_q     <= '0;
              state_q <= StL2;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        StL2: begin
          if (j_q == JW'(N2)) begin
            out_score <= acc_q;
            out_class <= !acc_q[ACC_W-1] && (acc_q != '0);
            out_valid <= 1'b1;
            j_q       <= '0;
            state_q   <= StDone;
          end else begin
            acc_q <= sum2;
            j_q   <= j_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MLP_DND_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_events <= '0;
      perf_signal <= '0;
    end else begin
      if (state_q == StIdle && in_valid && perf_events != 16'hFFFF) begin
        perf_events <= perf_events + 1'b1;
      end
      if (state_q == StDone && out_ready && out_class && perf_signal != 16'hFFFF) begin
        perf_signal <= perf_signal + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlp_dnd_sequencer.sv
// Bench for mlp_dnd_sequencer: directed vectors plus randomized vectors checked against a model.
module tb_mlp_dnd_sequencer;

  localparam int N2 = 10;
  localparam int NH = 49;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_class;
  logic [15:0] out_score;
  logic [NH-1:0][3:0] in_mag;
  logic [NH-1:0][1:0] in_pol;
  logic [N2-1:0][NH:0][5:0] w_mag, w_pol;
  logic [N2:0][3:0] w2;

  int passed = 0;
  int total = 0;

  mlp_dnd_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mag         (in_mag),
    .in_pol         (in_pol),
    .weights_n1_mag (w_mag),
    .weights_n1_pol (w_pol),
    .weights_n2     (w2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_score      (out_score),
    .out_class      (out_class)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic fill(input logic [5:0] wm, input logic [5:0] wp, input logic [3:0] n2w,
                      input logic [3:0] n2b, input logic [3:0] mg, input logic [1:0] pl);
    for (int j = 0; j < N2; j++) begin
      for (int i = 0; i <= NH; i++) begin
        w_mag[j][i] = wm;
        w_pol[j][i] = wp;
      end
      w2[j] = n2w;
    end
    w2[N2] = n2b;
    for (int i = 0; i < NH; i++) begin
      in_mag[i] = mg;
      in_pol[i] = pl;
    end
  endtask

  task automatic randomize_all();
    for (int j = 0; j < N2; j++) begin
      for (int i = 0; i <= NH; i++) begin
        w_mag[j][i] = 6'($urandom);
        w_pol[j][i] = 6'($urandom);
      end
    end
    for (int j = 0; j <= N2; j++) w2[j] = 4'($urandom);
    for (int i = 0; i < NH; i++) begin
      in_mag[i] = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       in_pol[i] = 2'b00;
        1:       in_pol[i] = 2'b01;
        default: in_pol[i] = 2'b11;
      endcase
    end
  endtask

  // Plain dot products: hidden = clip(bias + sum(wm*mag + wp*pol)), score = b2 + sum(w2*hid)
  function automatic int model_score();
    int h, score, wm, wp, mg, pl;
    score = $signed(w2[N2]);
    for (int j = 0; j < N2; j++) begin
      h = $signed(w_mag[j][NH]);
      for (int i = 0; i < NH; i++) begin
        wm = $signed(w_mag[j][i]);
        wp = $signed(w_pol[j][i]);
        mg = int'(in_mag[i]);
        pl = $signed(in_pol[i]);
        h += wm * mg + wp * pl;
      end
      if (h < 0) h = 0;
      if (h > 255) h = 255;
      score += int'($signed(w2[j])) * h;
    end
    return score;
  endfunction

  task automatic start_vector(input string tag);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_score);
    int cnt = 0;
    while (out_valid !== 1'b1 && cnt < 1000) begin
      if (cnt == 100) check({tag, "_in_ready_busy"}, in_ready, 0);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_latency"}, cnt, 501);
    check({tag, "_score"}, $signed(out_score), exp_score);
    check({tag, "_class"}, out_class, (exp_score > 0) ? 1 : 0);
  endtask

  task automatic handshake(input string tag, input int exp_score);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, out_valid, 0);
    check({tag, "_ready_after_hs"}, in_ready, 1);
    check({tag, "_score_kept"}, $signed(out_score), exp_score);
  endtask

  initial begin
    fill(6'd1, 6'd0, 4'd1, 4'd1, 4'd15, 2'b00);
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_score", $signed(out_score), 0);
    check("reset_out_class", out_class, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: every hidden sum is 736, clipped to 255
    fill(6'd1, 6'd0, 4'd1, 4'd1, 4'd15, 2'b00);
    start_vector("sat");
    wait_result("sat", 2551);
    handshake("sat", 2551);

    // ReLU zero: all hidden negative
    fill(6'h3F, 6'd0, 4'd5, 4'hD, 4'd15, 2'b00);
    start_vector("relu");
    wait_result("relu", -3);
    handshake("relu", -3);

    // Polarity path only
    fill(6'd0, 6'd2, 4'd1, 4'd0, 4'd0, 2'b01);
    start_vector("pol");
    wait_result("pol", 980);
    handshake("pol", 980);

    // Backpressure with in_valid pulses in DONE
    start_vector("bp");
    wait_result("bp", 980);
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_score_held", $signed(out_score), 980);
      check("bp_class_held", out_class, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake("bp", 980);

    // Abort mid-L1 with asynchronous reset, then rerun
    fill(6'd1, 6'd0, 4'd1, 4'd1, 4'd15, 2'b00);
    start_vector("abort");
    repeat (200) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_score", $signed(out_score), 0);
    check("abort_out_class", out_class, 0);
    @(negedge clk);
    rst = 1'b0;
    start_vector("rerun");
    wait_result("rerun", 2551);
    handshake("rerun", 2551);

    for (int r = 0; r < 4; r++) begin
      int exp_s;
      randomize_all();
      exp_s = model_score();
      start_vector("rand");
      wait_result("rand", exp_s);
      handshake("rand", exp_s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mlp_dnd_sequencer.md
Name: mlp_dnd_sequencer

Overview:
- Time-multiplexed inference controller for the two-layer denoising MLP.
- Accepts one event feature vector: N1/2 magnitude features plus N1/2 polarity features.
- Walks the hidden layer, then the output layer, one weight column per cycle, using a shared MAC.
- Weights come from the constant weight-table block (first-layer magnitude/polarity tables, second-layer table). Returns a signed score and a signal/noise decision.

Parameters:
N1, 98, total first-layer inputs (N1/2 magnitude + N1/2 polarity)
N2, 10, hidden neurons
MAG_W, 4, unsigned magnitude-feature width
HID_W, 8, unsigned saturated hidden-activation width
ACC_W, 16, signed accumulator and score width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  feature vector valid
in_ready  out  1  block can accept a vector
in_mag  in  [N1/2-1:0][MAG_W-1:0]  unsigned magnitude features
in_pol  in  [N1/2-1:0][1:0]  signed polarity features, values -1/0/+1
weights_n1_mag  in  [N2-1:0][N1/2:0][5:0]  signed; element N1/2 is the hidden bias
weights_n1_pol  in  [N2-1:0][N1/2:0][5:0]  signed; element N1/2 ignored
weights_n2  in  [N2:0][3:0]  signed; element N2 is the output bias
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_score  out  ACC_W  signed output-layer sum
out_class  out  1  1 when out_score > 0

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_score=0, out_class=0; counters, accumulator and hidden registers 0. Reset is asynchronous and active-high; it aborts any inference in progress.
- FSM states: IDLE, L1, L2, DONE.
- in_ready is 1 only in IDLE.
- IDLE: on in_valid & in_ready, register in_mag and in_pol. Set j=0, i=0 and go to L1.
- L1 (N2*N1/2 cycles): each cycle computes term = w_mag[j][i]*in_mag[i] + w_pol[j][i]*in_pol[i].
  - Magnitude is zero-extended to signed; products are sign-extended to ACC_W.
  - At i=0: acc <= w_mag[j][N1/2] + term. Otherwise acc <= acc + term.
  - At i=N1/2-1: hid[j] <= clip(acc+term, 0, 2^HID_W-1), i.e. ReLU with saturation. Then i wraps to 0 and j increments.
  - After j=N2-1 completes, go to L2 with j=0.
- L2 (N2 cycles):
  - At j=0: acc <= weights_n2[N2] + weights_n2[0]*hid[0]. Otherwise acc <= acc + weights_n2[j]*hid[j]. hid is zero-extended.
  - On the last cycle, register out_score and out_class from the final sum, set out_valid=1 and go to DONE.
- Accumulator overflow wraps modulo 2^ACC_W. This cannot occur with default parameters.
- Latency: vector accepted at edge k; out_valid rises at edge k + N2*(N1/2) + N2 + 1, which is edge k+501 at defaults.
- DONE:
  - out_valid, out_score and out_class are held stable until out_ready=1.
  - On the out handshake edge: out_valid <= 0, state IDLE, and in_ready is 1 from the next cycle.
  - out_score and out_class keep their last value after the handshake.
- in_valid outside IDLE is ignored; no input buffering.
- Weight ports are sampled combinationally each cycle. The caller keeps them constant.

Optional Feature:
MLP_DND_SEQ_PERF_CNT_EN
- Defined: adds output ports perf_events [15:0] and perf_signal [15:0].
  - perf_events counts accepted input vectors; perf_signal counts out handshakes with out_class=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, out_score=0, out_class=0.
- Saturation path: all w_mag=+1 including bias, w_pol=0, weights_n2 all +1, in_mag all 15 -> hidden acc 736 clipped to 255. Expect out_score=2551, out_class=1, out_valid exactly 501 cycles after the accept edge.
- ReLU zero: all w_mag=-1, in_mag all 15, weights_n2 bias=-3, other n2 weights +5 -> all hid=0, out_score=-3, out_class=0.
- Polarity path: w_mag=0 including bias, w_pol=+2, in_pol all +1, weights_n2 bias 0 and others +1 -> hid=98 each, out_score=980.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, pulsing in_valid -> score/class/out_valid stable, in_ready=0, pulses ignored. After out_ready=1: out_valid=0 and in_ready=1 on the next cycle.
- Abort: assert rst at cycle 200 of L1, release, rerun the saturation vector -> out_score=2551 with no residue from the aborted run.
